// File: rtl/register_file_pkg.sv
// Shared CPU constants: data width, register count, register-index width and
// the instruction fields the core decodes register indices from.
package register_file_pkg;

    localparam int unsigned CPU_XLEN  = 64;
    localparam int unsigned CPU_NREGS = 32;
    localparam int unsigned REG_IDX_W = $clog2(CPU_NREGS);
    localparam int unsigned INSTR_W   = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    function automatic reg_idx_t instr_rs1(input logic [INSTR_W-1:0] instr);
        return instr[19:15];
    endfunction

    function automatic reg_idx_t instr_rs2(input logic [INSTR_W-1:0] instr);
        return instr[24:20];
    endfunction

    function automatic reg_idx_t instr_rd(input logic [INSTR_W-1:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/register_file.sv
// RISC-V integer register file: one write port, two combinational read ports
// with write-through bypass; x0 hardwired to zero.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned XLEN  = CPU_XLEN,
    parameter int unsigned NREGS = CPU_NREGS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic [XLEN-1:0]      write_data,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] rs1,
    output logic [XLEN-1:0]      data1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic [XLEN-1:0]      data2
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en_c;

    // A write is live only out of reset and never for x0; this also gates the bypass.
    assign wr_en_c = reset && we && (rd != '0);

    // regs[0] is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '{default: '0};
        end else if (wr_en_c) begin
            regs[rd] <= write_data;
        end
    end

    always_comb begin
        data1 = '0;
        data2 = '0;
        if (reset) begin
            if (rs1 != '0) begin
                data1 = (wr_en_c && (rs1 == rd)) ? write_data : regs[rs1];
            end
            if (rs2 != '0) begin
                data2 = (wr_en_c && (rs2 == rd)) ? write_data : regs[rs2];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: expected read values are queued when
// read addresses are driven and popped when the ports are sampled.
module tb_register_file;
    import register_file_pkg::*;

    localparam int unsigned XLEN = CPU_XLEN;

    logic                 clk;
    logic                 clk_en;
    logic                 reset;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      write_data;
    logic                 we;
    logic [REG_IDX_W-1:0] rs1;
    logic [XLEN-1:0]      data1;
    logic [REG_IDX_W-1:0] rs2;
    logic [XLEN-1:0]      data2;

    typedef struct {
        string          tag;
        logic [XLEN-1:0] val;
    } exp_t;

    exp_t            sb_q [$];
    logic [XLEN-1:0] model [32];
    int              n_checks;
    int              n_fails;

    register_file dut (
        .clk        (clk),
        .reset      (reset),
        .rd         (rd),
        .write_data (write_data),
        .we         (we),
        .rs1        (rs1),
        .data1      (data1),
        .rs2        (rs2),
        .data2      (data2)
    );

    // Gated clock so the initial reset can be exercised with no edges at all.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                            input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_read(input logic [REG_IDX_W-1:0] idx);
        if (!reset || idx == '0) return '0;
        if (we && rd != '0 && rd == idx) return write_data;
        return model[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Drive both read indices, push expectations, then sample and compare.
    task automatic read_pair(input string tag, input logic [REG_IDX_W-1:0] a,
                             input logic [REG_IDX_W-1:0] b);
        exp_t e;
        rs1 = a;
        rs2 = b;
        e.tag = {tag, "/data1"}; e.val = exp_read(a); sb_q.push_back(e);
        e.tag = {tag, "/data2"}; e.val = exp_read(b); sb_q.push_back(e);
        #1;
        e = sb_q.pop_front(); check_eq(e.tag, data1, e.val);
        e = sb_q.pop_front(); check_eq(e.tag, data2, e.val);
    endtask

    // Present a write at the falling edge, commit at the rising edge, update model.
    task automatic do_write(input logic w, input logic [REG_IDX_W-1:0] idx,
                            input logic [XLEN-1:0] d);
        @(negedge clk);
        we = w; rd = idx; write_data = d;
        @(posedge clk);
        if (reset && w && idx != '0) model[idx] = d;
        #1;
        we = 1'b0;
    endtask

    initial begin
        clk = 1'b0; clk_en = 1'b0; reset = 1'b0;
        we = 1'b0; rd = '0; write_data = '0; rs1 = '0; rs2 = '0;
        n_checks = 0; n_fails = 0;
        clear_model();

        // Reset with no clock edge and a pending write: everything reads 0.
        #2;
        we = 1'b1; rd = 5'd5; write_data = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 32; i++) read_pair("rst_noclk", 5'(i), 5'(31 - i));
        read_pair("rst_bypass", 5'd5, 5'd5);
        we = 1'b0;
        #1;
        reset = 1'b1;
        clk_en = 1'b1;

        // First edge after release accepts a write.
        do_write(1'b1, 5'd4, 64'h0000_0000_0000_0444);
        read_pair("first_wr", 5'd4, 5'd0);

        do_write(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567);
        read_pair("wr_rd_x5", 5'd5, 5'd5);

        // x0 write ignored, also before the edge (no bypass for rd=0).
        @(negedge clk);
        we = 1'b1; rd = 5'd0; write_data = 64'hFFFF_FFFF_FFFF_FFFF;
        read_pair("x0_pre", 5'd0, 5'd0);
        @(posedge clk);
        #1;
        we = 1'b0;
        read_pair("x0_post", 5'd0, 5'd0);

        // Bypass on rs1, unrelated rs2 untouched.
        do_write(1'b1, 5'd7, 64'd1);
        do_write(1'b1, 5'd6, 64'd66);
        @(negedge clk);
        we = 1'b1; rd = 5'd7; write_data = 64'd42;
        read_pair("bypass", 5'd7, 5'd6);
        read_pair("bypass_same", 5'd7, 5'd7);
        @(posedge clk);
        model[7] = 64'd42;
        #1;
        we = 1'b0;
        read_pair("bypass_after", 5'd7, 5'd6);

        // Write disable.
        do_write(1'b1, 5'd3, 64'd10);
        do_write(1'b0, 5'd3, 64'd99);
        read_pair("we_off", 5'd0, 5'd3);

        // Full sweep.
        for (int i = 1; i < 32; i++) do_write(1'b1, 5'(i), 64'(i) * 64'h0101);
        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
                read_pair("sweep", 5'(a), 5'(b));

        // Reset mid-cycle during a write: reads 0 immediately and after release.
        @(negedge clk);
        we = 1'b1; rd = 5'd9; write_data = 64'hCAFE_F00D_CAFE_F00D;
        #2;
        reset = 1'b0;
        clear_model();
        for (int i = 0; i < 32; i++) read_pair("rst_mid", 5'(i), 5'(i ^ 1));
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) read_pair("post_rst", 5'(i), 5'(31 - i));

        do_write(1'b1, 5'd31, 64'h0F0F_0F0F_0F0F_0F0F);
        read_pair("rewrite", 5'd31, 5'd9);

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Hard bound on runtime in case the clock stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
